input_irq_ctrl: RTL and testbench

Parametrised, multi-channel input change-interrupt controller on an Avalon-MM slave. Each of WIDTH asynchronous inputs (switches, buttons, external status lines) is synchronised, debounced and edge-detected. Selected rising and/or falling edges are latched into a write-1-to-clear capture register. A level interrupt to the HPS is raised while any unmasked capture bit is set. It replaces single-purpose 4-bit change detectors in the FPGA fabric.

---
 rtl/input_irq_ctrl.sv | 125 ++++++++++++
 tb/tb_input_irq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_irq_ctrl.sv
`default_nettype none
// input_irq_ctrl: per-channel synchroniser, debouncer and edge detector feeding a
// write-1-to-clear capture register with a masked level interrupt, on an Avalon-MM slave.
module input_irq_ctrl #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic              FPGA_CLK1_50,
  input  logic              reset,
  input  logic [WIDTH-1:0]  inputs,
  input  logic [2:0]        avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [WIDTH-1:0]  avl_writedata,
  output logic [WIDTH-1:0]  avl_readdata,
  output logic              avl_irq
);

  localparam logic [2:0] ADDR_STATE   = 3'd0;
  localparam logic [2:0] ADDR_CAPTURE = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_prev;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] read_mux;

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], inputs};
    end
  end

  assign sync_out = sync_chain[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = sync_out;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CW-1:0] count;
        logic          level;

        // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge FPGA_CLK1_50) begin
          if (reset) begin
            count <= '0;
            level <= 1'b0;
          end else if (sync_out[i] != level) begin
            if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
              level <= sync_out[i];
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end else begin
            count <= '0;
          end
        end

        assign stable[i] = level;
      end
    end
  endgenerate

  assign rise = stable & ~stable_prev & rise_en;
  assign fall = ~stable & stable_prev & fall_en;
  assign clr  = (avl_write && avl_address == ADDR_CAPTURE) ? avl_writedata : '0;

  always_comb begin
    read_mux = '0;
    case (avl_address)
      ADDR_STATE:   read_mux = stable;
      ADDR_CAPTURE: read_mux = capture;
      ADDR_MASK:    read_mux = mask;
      ADDR_RISE_EN: read_mux = rise_en;
      ADDR_FALL_EN: read_mux = fall_en;
      default:      read_mux = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a coincident set wins.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      stable_prev  <= '0;
      capture      <= '0;
      mask         <= '0;
      rise_en      <= '1;
      fall_en      <= '1;
      avl_irq      <= 1'b0;
      avl_readdata <= '0;
    end else begin
      stable_prev <= stable;
      capture     <= (capture & ~clr) | rise | fall;
      avl_irq     <= |(capture & mask);
      if (avl_write) begin
        case (avl_address)
          ADDR_MASK:    mask    <= avl_writedata;
          ADDR_RISE_EN: rise_en <= avl_writedata;
          ADDR_FALL_EN: fall_en <= avl_writedata;
          default:      ;
        endcase
      end
      if (avl_read) begin
        avl_readdata <= read_mux;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_irq_ctrl.sv
`default_nettype none
// tb_input_irq_ctrl: scenario tasks with a read-data scoreboard for input_irq_ctrl.
module tb_input_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] inputs = '0;
  logic [2:0] avl_address = '0;
  logic       avl_read = 1'b0;
  logic       avl_write = 1'b0;
  logic [3:0] avl_writedata = '0;
  logic [3:0] avl_readdata;
  logic       avl_irq;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];
  logic [3:0] got_q[$];
  logic       rd_q = 1'b0;
  logic [3:0] got;
  logic [3:0] exp;
  string      nm;

  input_irq_ctrl #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .FPGA_CLK1_50(clk),
    .reset(reset),
    .inputs(inputs),
    .avl_address(avl_address),
    .avl_read(avl_read),
    .avl_write(avl_write),
    .avl_writedata(avl_writedata),
    .avl_readdata(avl_readdata),
    .avl_irq(avl_irq)
  );

  always #10 clk = ~clk;

  // Read-data monitor: data is valid in the cycle after the strobe was sampled.
  always @(posedge clk) rd_q <= avl_read;
  always @(negedge clk) if (rd_q) got_q.push_back(avl_readdata);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [3:0] data);
    avl_address = addr;
    avl_writedata = data;
    avl_write = 1'b1;
    tick();
    avl_write = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] addr, input logic [3:0] expected, input string name);
    exp_q.push_back(expected);
    name_q.push_back(name);
    avl_address = addr;
    avl_read = 1'b1;
    tick();
    avl_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] reset_vals [8];
    reset_vals = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    reset = 1'b1;
    inputs = 4'h0;
    tick(3);
    reset = 1'b0;
    tick(20);
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", avl_irq);
    end
    checks++;
    if (avl_readdata !== 4'h0) begin
      errors++;
      $display("FAIL reset_readdata: got %h expected 0", avl_readdata);
    end
    for (int a = 0; a < 8; a++) do_read(3'(a), reset_vals[a], $sformatf("reset_reg%0d", a));
    tick();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no read data, expected %h", nm, exp); end
      else begin got = got_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, exp); end end
    end
  endtask

  task automatic test_rise_irq();
    do_write(3'd2, 4'hF);
    inputs = 4'h1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (avl_irq !== (k == 8)) begin
        errors++;
        $display("FAIL rise_latency_edge%0d: irq got %b expected %b", k, avl_irq, (k == 8));
      end
    end
    do_read(3'd1, 4'h1, "rise_capture");
    do_read(3'd0, 4'h1, "rise_state");
    tick();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no read data, expected %h", nm, exp); end
      else begin got = got_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, exp); end end
    end
  endtask

  task automatic test_clear();
    do_write(3'd1, 4'h1);
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL clear_irq_same_edge: got %b expected 1", avl_irq);
    end
    tick();
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL clear_irq_next_edge: got %b expected 0", avl_irq);
    end
    do_read(3'd1, 4'h0, "clear_capture");
    tick();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no read data, expected %h", nm, exp); end
      else begin got = got_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, exp); end end
    end
  endtask

  task automatic test_glitch();
    inputs = 4'h5;
    tick(3);
    inputs = 4'h1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (avl_irq !== 1'b0) begin
        errors++;
        $display("FAIL glitch_irq_cycle%0d: got %b expected 0", k, avl_irq);
      end
    end
    do_read(3'd0, 4'h1, "glitch_state");
    do_read(3'd1, 4'h0, "glitch_capture");
    inputs = 4'h5;
    tick(4);
    inputs = 4'h1;
    tick(15);
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL pulse4_irq: got %b expected 1", avl_irq);
    end
    do_read(3'd1, 4'h4, "pulse4_capture");
    do_read(3'd0, 4'h1, "pulse4_state");
    do_write(3'd1, 4'h4);
    tick();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no read data, expected %h", nm, exp); end
      else begin got = got_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, exp); end end
    end
  endtask

  task automatic test_fall_mask();
    do_write(3'd4, 4'h0);
    inputs = 4'h3;
    tick(10);
    inputs = 4'h1;
    tick(10);
    do_read(3'd1, 4'h2, "fall_dis_capture");
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL fall_dis_irq: got %b expected 1", avl_irq);
    end
    do_write(3'd2, 4'h0);
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL mask_irq_same_edge: got %b expected 1", avl_irq);
    end
    tick();
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_irq_next_edge: got %b expected 0", avl_irq);
    end
    do_read(3'd1, 4'h2, "mask_capture_kept");
    tick();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no read data, expected %h", nm, exp); end
      else begin got = got_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, exp); end end
    end
  endtask

  task automatic test_set_wins_reset();
    do_write(3'd2, 4'hF);
    do_write(3'd4, 4'hF);
    do_write(3'd1, 4'h2);
    inputs = 4'h9;
    tick(6);
    do_write(3'd1, 4'h8);
    do_read(3'd1, 4'h8, "set_wins_capture");
    do_write(3'd1, 4'h8);
    inputs = 4'hB;
    tick(3);
    reset = 1'b1;
    tick(2);
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_irq: got %b expected 0", avl_irq);
    end
    reset = 1'b0;
    do_write(3'd2, 4'hF);
    for (int k = 2; k <= 8; k++) begin
      tick();
      checks++;
      if (avl_irq !== (k == 8)) begin
        errors++;
        $display("FAIL postreset_edge%0d: irq got %b expected %b", k, avl_irq, (k == 8));
      end
    end
    do_read(3'd1, 4'hB, "postreset_capture");
    do_read(3'd0, 4'hB, "postreset_state");
    tick();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL %s: no read data, expected %h", nm, exp); end
      else begin got = got_q.pop_front(); if (got !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, exp); end end
    end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_clear();
    test_glitch();
    test_fall_mask();
    test_set_wins_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
